ndp_stream_deserializer: RTL and testbench
==========================================

# ndp_stream_deserializer

Parametrised AXI4-Stream-to-operand deserializer that sits between the DMA master stream and the NDP core input. It accepts beats of any width that is a multiple of the element width, assembles each frame into one A-operand vector followed by one B-operand vector, and checks frame framing against `tlast`. It presents each completed frame to the core through a registered valid/ready handshake, and exposes frame and error counters plus debug taps.

## Interface
Parameters:
- `AXIS_W`, 32: stream data width. Must be a multiple of `ELEM_W`.
- `ELEM_W`, 16: operand element width (fp16 by default).
- `A_ELEMS`, 4: elements per A vector (`SYS_HEIGHT*ARR_HEIGHT`). `A_ELEMS*ELEM_W` must be a multiple of `AXIS_W`.
- `B_ELEMS`, 64: elements per B vector (`SYS_WIDTH*ARR_WIDTH`). `B_ELEMS*ELEM_W` must be a multiple of `AXIS_W`.
- `ERR_CNT_W`, 16: error counter width.

Derived values:
- `A_BEATS = A_ELEMS*ELEM_W/AXIS_W`.
- `B_BEATS = B_ELEMS*ELEM_W/AXIS_W`.

Ports:
- `axi_aclk`, in, 1: the single clock.
- `axi_aresetn`, in, 1: asynchronous, active-low reset.
- `s_axis_tdata`, in, `AXIS_W`: input stream data.
- `s_axis_tvalid`, in, 1: input beat valid.
- `s_axis_tlast`, in, 1: last beat of the frame.
- `s_axis_tready`, out, 1: block can accept a beat.
- `out_a`, out, `A_ELEMS*ELEM_W`: assembled A vector.
- `out_b`, out, `B_ELEMS*ELEM_W`: assembled B vector.
- `out_valid`, out, 1: frame available to the NDP core.
- `out_ready`, in, 1: NDP core accepts the frame.
- `frame_cnt`, out, 32: number of frames delivered.
- `err_cnt`, out, `ERR_CNT_W`: number of framing errors.
- `err_pulse`, out, 1: one-cycle pulse on each framing error.
- `state_debug`, out, 2: current FSM state encoding.
- `beat_cnt_debug`, out, `$clog2(B_BEATS+1)`: current beat counter.

## Operation
- The FSM has four states, encoded as LOAD_A=0, LOAD_B=1, HOLD=2, DRAIN=3.
- `s_axis_tready` is 1 in LOAD_A, LOAD_B and DRAIN, and 0 in HOLD. It is a pure function of the state.
- A beat is accepted on `s_axis_tvalid & s_axis_tready`.
- Packing rule: accepted beat k of a vector is written to bits `[k*AXIS_W +: AXIS_W]`. Element 0 of a beat is `tdata[ELEM_W-1:0]`. There is no reordering and no arithmetic.
- LOAD_A:
  - Each accepted beat fills `out_a` and increments the beat counter.
  - After beat `A_BEATS-1` is accepted, the counter clears and the FSM moves to LOAD_B.
- LOAD_B:
  - Each accepted beat fills `out_b`.
  - On beat `B_BEATS-1` with `tlast`=1, the FSM moves to HOLD.
- HOLD:
  - `out_valid`=1. `out_a` and `out_b` are stable.
  - On `out_ready`, the FSM returns to LOAD_A and `frame_cnt` increments (wrapping).
- Early `tlast`: `tlast`=1 on any accepted beat other than the final B beat.
  - The frame is discarded and `err_pulse` fires.
  - The FSM goes to LOAD_A.
- Missing `tlast`: the final B beat is accepted with `tlast`=0.
  - The frame is discarded and `err_pulse` fires.
  - The FSM goes to DRAIN.
- DRAIN: accepted beats are dropped. The FSM goes to LOAD_A on the cycle after a beat with `tlast`=1 is accepted.
- `err_cnt` increments on every `err_pulse` and saturates at all-ones.
- Discarded frames do not clear the data registers, but `out_valid` is never raised for them.

## Timing
- Reset values:
  - State is LOAD_A and the beat counter is 0.
  - `out_a`, `out_b`, `frame_cnt` and `err_cnt` are 0.
  - `out_valid` and `err_pulse` are 0, and `s_axis_tready` is 1.
- Latency: `out_valid` rises on the cycle after the final B beat is accepted.
- Back-to-back frames: `out_ready` may be held high. The next frame's first beat can then be accepted on the cycle after the handshake.
- Minimum frame period is `A_BEATS+B_BEATS+1` cycles.
- `out_valid` is registered and never drops without a handshake.
- `err_pulse` is registered, one cycle high, and asserted the cycle after the offending beat.
- Reset mid-frame: the partial frame is lost and all outputs return to their reset values immediately (asynchronously).
- Gaps in `s_axis_tvalid` stall counting without any other effect.

## Structure
- A shared package `ndp_pkg` holds:
  - the state enum;
  - a `clog2`-based beat-count width function;
  - defaults mirroring the system parameters (`WIDTH`, `ARR_*`, `SYS_*`).
- Sub-module `ndp_vec_packer`: one shift-free indexed-write register bank, parametrised by beats. It is instantiated twice, for A and for B.
- The FSM and counters live in the top module.

## Test plan
- Defaults, with 34 beats carrying incrementing elements 0x0000..0x0043 and `tlast` on beat 33, `out_ready`=1:
  - `out_a` = {0x0003,0x0002,0x0001,0x0000};
  - `out_b[15:0]` = 0x0004;
  - `out_valid` is high for 1 cycle, on the cycle after beat 33;
  - `frame_cnt` = 1.
- The same frame with `out_ready`=0 for 10 cycles:
  - `tready`=0 throughout and `out_valid` holds;
  - outputs stay stable;
  - the next frame is accepted the cycle after the handshake.
- `tlast` on beat 5:
  - `err_pulse` fires once and `err_cnt` = 1;
  - no `out_valid`;
  - the following good frame is delivered correctly.
- 34 beats with no `tlast`, then 3 extra beats with `tlast` on the third:
  - `err_cnt` = 1;
  - the FSM is in DRAIN for those beats, then LOAD_A;
  - no `out_valid`.
- `AXIS_W`=64:
  - a frame is 17 beats;
  - the element packing matches the 32-bit case.
- Assert reset during LOAD_B at beat 10:
  - all outputs reset immediately;
  - a subsequent full frame is delivered correctly.
- With `ERR_CNT_W`=2 and 5 early-`tlast` frames, `err_cnt` saturates at 3.

Source files
------------

// File: rtl/ndp_stream_deserializer_pkg.sv
// Shared types and defaults for the NDP stream deserializer.
package ndp_pkg;

  // Default system geometry; operand vector sizes derive from these.
  localparam int WIDTH      = 16;
  localparam int ARR_HEIGHT = 1;
  localparam int ARR_WIDTH  = 16;
  localparam int SYS_HEIGHT = 4;
  localparam int SYS_WIDTH  = 4;

  // Deserializer FSM states; encodings are visible on state_debug.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } ndp_state_e;

  // Width of a counter that must hold values 0..beats.
  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/ndp_stream_deserializer_if.sv
// Stream-in / operand-out bundle of the deserializer.
//
// Handshakes: a stream beat transfers on a rising edge where s_axis_tvalid
// and s_axis_tready are both high; an operand frame transfers on a rising
// edge where out_valid and out_ready are both high. A raised valid is held,
// with its payload stable, until the matching transfer.
interface ndp_stream_deserializer_if #(
  parameter int AXIS_W  = 32,
  parameter int ELEM_W  = 16,
  parameter int A_ELEMS = 4,
  parameter int B_ELEMS = 64
) ();

  logic [AXIS_W-1:0]         s_axis_tdata;
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic                      s_axis_tready;
  logic [A_ELEMS*ELEM_W-1:0] out_a;
  logic [B_ELEMS*ELEM_W-1:0] out_b;
  logic                      out_valid;
  logic                      out_ready;

  // Environment side: drives the stream, consumes operand frames.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, out_ready,
    input  s_axis_tready, out_a, out_b, out_valid
  );

  // Deserializer side.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, out_ready,
    output s_axis_tready, out_a, out_b, out_valid
  );

endinterface

// File: rtl/ndp_stream_deserializer_vec_packer.sv
// Indexed-write register bank: beat idx lands in slice [idx*AXIS_W +: AXIS_W].
module ndp_vec_packer #(
  parameter int BEATS  = 2,
  parameter int AXIS_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CNT_W-1:0]        idx,
  input  logic [AXIS_W-1:0]       data,
  output logic [BEATS*AXIS_W-1:0] vec
);

  // Write the addressed slice only; other slices keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        if (wr_en && (idx == CNT_W'(i))) begin
          vec[i*AXIS_W +: AXIS_W] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/ndp_stream_deserializer.sv
// AXI4-Stream to A/B operand deserializer with tlast framing checks.
module ndp_stream_deserializer
  import ndp_pkg::*;
#(
  parameter int AXIS_W    = 32,
  parameter int ELEM_W    = WIDTH,
  parameter int A_ELEMS   = SYS_HEIGHT * ARR_HEIGHT,
  parameter int B_ELEMS   = SYS_WIDTH * ARR_WIDTH,
  parameter int ERR_CNT_W = 16,
  localparam int A_BEATS  = A_ELEMS * ELEM_W / AXIS_W,
  localparam int B_BEATS  = B_ELEMS * ELEM_W / AXIS_W,
  localparam int CNT_W    = beat_cnt_w(B_BEATS)
) (
  input  logic                           axi_aclk,
  input  logic                           axi_aresetn,
  ndp_stream_deserializer_if.slave       bus,
  output logic [31:0]                    frame_cnt,
  output logic [ERR_CNT_W-1:0]           err_cnt,
  output logic                           err_pulse,
  output logic [1:0]                     state_debug,
  output logic [CNT_W-1:0]               beat_cnt_debug
);

  ndp_state_e                state, state_next;
  logic [CNT_W-1:0]          beat_cnt, beat_cnt_next;
  logic                      err_next;
  logic                      frame_done;
  logic                      accept;
  logic                      a_wr, b_wr;
  logic                      out_valid_q;
  logic [A_ELEMS*ELEM_W-1:0] vec_a;
  logic [B_ELEMS*ELEM_W-1:0] vec_b;

  assign bus.s_axis_tready = (state != HOLD);
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
  assign a_wr              = accept & (state == LOAD_A);
  assign b_wr              = accept & (state == LOAD_B);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_a         = vec_a;
  assign bus.out_b         = vec_b;
  assign state_debug       = state;
  assign beat_cnt_debug    = beat_cnt;

  ndp_vec_packer #(
    .BEATS (A_BEATS),
    .AXIS_W(AXIS_W),
    .CNT_W (CNT_W)
  ) u_pack_a (
    .clk  (axi_aclk),
    .rst_n(axi_aresetn),
    .wr_en(a_wr),
    .idx  (beat_cnt),
    .data (bus.s_axis_tdata),
    .vec  (vec_a)
  );

  ndp_vec_packer #(
    .BEATS (B_BEATS),
    .AXIS_W(AXIS_W),
    .CNT_W (CNT_W)
  ) u_pack_b (
    .clk  (axi_aclk),
    .rst_n(axi_aresetn),
    .wr_en(b_wr),
    .idx  (beat_cnt),
    .data (bus.s_axis_tdata),
    .vec  (vec_b)
  );

  // Next state, beat count, framing errors and frame completion.
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    err_next      = 1'b0;
    frame_done    = 1'b0;
    case (state)
      LOAD_A: begin
        if (accept) begin
          if (bus.s_axis_tlast) begin
            // tlast can only legally sit on the final B beat.
            err_next      = 1'b1;
            beat_cnt_next = '0;
          end else if (beat_cnt == CNT_W'(A_BEATS - 1)) begin
            state_next    = LOAD_B;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (beat_cnt == CNT_W'(B_BEATS - 1)) begin
            beat_cnt_next = '0;
            if (bus.s_axis_tlast) begin
              state_next = HOLD;
            end else begin
              // Frame overran: discard and skip to the real tlast.
              err_next   = 1'b1;
              state_next = DRAIN;
            end
          end else if (bus.s_axis_tlast) begin
            err_next      = 1'b1;
            state_next    = LOAD_A;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = LOAD_A;
          frame_done = 1'b1;
        end
      end
      DRAIN: begin
        if (accept && bus.s_axis_tlast) begin
          state_next = LOAD_A;
        end
      end
      default: begin
        state_next    = LOAD_A;
        beat_cnt_next = '0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= LOAD_A;
      beat_cnt    <= '0;
      out_valid_q <= 1'b0;
      err_pulse   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_next;
      beat_cnt    <= beat_cnt_next;
      out_valid_q <= (state_next == HOLD);
      err_pulse   <= err_next;
      if (frame_done) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (err_next && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ndp_stream_deserializer.sv
// Directed bench: dut0 uses defaults, dut1 uses a 64-bit stream and a 2-bit
// error counter. Delivered frames are checked against an expected queue.
module tb_ndp_stream_deserializer;

  localparam int VW = 1088;  // {out_b, out_a} width: 68 elements of 16 bits

  logic clk = 1'b0;
  logic rst_n0 = 1'b0;
  logic rst_n1 = 1'b0;

  always #5 clk = ~clk;

  ndp_stream_deserializer_if #(.AXIS_W(32), .ELEM_W(16), .A_ELEMS(4), .B_ELEMS(64)) bus0 ();
  ndp_stream_deserializer_if #(.AXIS_W(64), .ELEM_W(16), .A_ELEMS(4), .B_ELEMS(64)) bus1 ();

  logic [31:0] frame_cnt0, frame_cnt1;
  logic [15:0] err_cnt0;
  logic [1:0]  err_cnt1;
  logic        err_pulse0, err_pulse1;
  logic [1:0]  state0, state1;
  logic [5:0]  beat_cnt0;
  logic [4:0]  beat_cnt1;

  ndp_stream_deserializer #(.AXIS_W(32), .ELEM_W(16), .A_ELEMS(4), .B_ELEMS(64), .ERR_CNT_W(16)) dut0 (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n0),
    .bus           (bus0),
    .frame_cnt     (frame_cnt0),
    .err_cnt       (err_cnt0),
    .err_pulse     (err_pulse0),
    .state_debug   (state0),
    .beat_cnt_debug(beat_cnt0)
  );

  ndp_stream_deserializer #(.AXIS_W(64), .ELEM_W(16), .A_ELEMS(4), .B_ELEMS(64), .ERR_CNT_W(2)) dut1 (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n1),
    .bus           (bus1),
    .frame_cnt     (frame_cnt1),
    .err_cnt       (err_cnt1),
    .err_pulse     (err_pulse1),
    .state_debug   (state1),
    .beat_cnt_debug(beat_cnt1)
  );

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  logic [VW-1:0] exp_q0[$];
  logic [VW-1:0] exp_q1[$];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Expected {out_b, out_a}: element i holds base+i.
  function automatic logic [VW-1:0] frame_vec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < 68; i++) v[i*16 +: 16] = 16'(base + i);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready0();
    int n = 0;
    while (!bus0.s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.s_axis_tready) fail_now("tready0_timeout");
  endtask

  task automatic wait_ready1();
    int n = 0;
    while (!bus1.s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.s_axis_tready) fail_now("tready1_timeout");
  endtask

  // Beats first..last of a frame on dut0; tlast on beat tlast_at (-1: none).
  task automatic send0(input int base, input int first, input int last, input int tlast_at, input int gap_max);
    for (int k = first; k <= last; k++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
      end
      bus0.s_axis_tdata  = {16'(base + 2*k + 1), 16'(base + 2*k)};
      bus0.s_axis_tvalid = 1'b1;
      bus0.s_axis_tlast  = (k == tlast_at);
      wait_ready0();
      @(posedge clk);
      #1;
      bus0.s_axis_tvalid = 1'b0;
      bus0.s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send1(input int base, input int first, input int last, input int tlast_at);
    for (int k = first; k <= last; k++) begin
      bus1.s_axis_tdata  = {16'(base + 4*k + 3), 16'(base + 4*k + 2), 16'(base + 4*k + 1), 16'(base + 4*k)};
      bus1.s_axis_tvalid = 1'b1;
      bus1.s_axis_tlast  = (k == tlast_at);
      wait_ready1();
      @(posedge clk);
      #1;
      bus1.s_axis_tvalid = 1'b0;
      bus1.s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic wait_drain0();
    int n = 0;
    while (exp_q0.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q0.size() != 0) fail_now("drain0_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain1();
    int n = 0;
    while (exp_q1.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q1.size() != 0) fail_now("drain1_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;

  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (rst_n0) begin
      if (pv0 && !pr0) chk("valid_hold0", bus0.out_valid, 1);
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q0.size() == 0) begin
          chk("unexpected_frame0", 0, 1);
        end else begin
          e = exp_q0.pop_front();
          chk("frame0", {bus0.out_b, bus0.out_a}, e);
        end
      end
      if (err_pulse0) pulses0++;
      pv0 = bus0.out_valid;
      pr0 = bus0.out_ready;
    end else begin
      pv0 = 1'b0;
    end
    if (rst_n1) begin
      if (pv1 && !pr1) chk("valid_hold1", bus1.out_valid, 1);
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp_q1.size() == 0) begin
          chk("unexpected_frame1", 0, 1);
        end else begin
          e = exp_q1.pop_front();
          chk("frame1", {bus1.out_b, bus1.out_a}, e);
        end
      end
      if (err_pulse1) pulses1++;
      pv1 = bus1.out_valid;
      pr1 = bus1.out_ready;
    end else begin
      pv1 = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus0.s_axis_tdata = '0; bus0.s_axis_tvalid = 1'b0; bus0.s_axis_tlast = 1'b0; bus0.out_ready = 1'b1;
    bus1.s_axis_tdata = '0; bus1.s_axis_tvalid = 1'b0; bus1.s_axis_tlast = 1'b0; bus1.out_ready = 1'b1;
    #12;
    chk("rst_state0", state0, 0);
    chk("rst_beat0", beat_cnt0, 0);
    chk("rst_tready0", bus0.s_axis_tready, 1);
    chk("rst_valid0", bus0.out_valid, 0);
    chk("rst_err_cnt1", err_cnt1, 0);
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vec0", {bus0.out_b, bus0.out_a}, 0);
    chk("rst_frame_cnt0", frame_cnt0, 0);

    // Basic frame, out_ready held high.
    exp_q0.push_back(frame_vec(0));
    send0(0, 0, 33, 33, 0);
    chk("valid_rise", bus0.out_valid, 1);
    chk("hold_tready", bus0.s_axis_tready, 0);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", bus0.out_valid, 0);
    chk("frame_cnt_1", frame_cnt0, 1);
    chk("out_a_basic", bus0.out_a, 64'h0003_0002_0001_0000);
    chk("out_b_elem0", bus0.out_b[15:0], 16'h0004);
    chk("out_b_elem63", bus0.out_b[1023:1008], 16'h0043);

    // Backpressure: hold for 10 cycles.
    bus0.out_ready = 1'b0;
    exp_q0.push_back(frame_vec(16'h100));
    send0(16'h100, 0, 33, 33, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", bus0.out_valid, 1);
      chk("stall_tready", bus0.s_axis_tready, 0);
      chk("stall_state", state0, 2);
      chk("stall_data", {bus0.out_b, bus0.out_a}, frame_vec(16'h100));
    end
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b1;
    exp_q0.push_back(frame_vec(16'h180));
    bus0.s_axis_tdata  = {16'h0181, 16'h0180};
    bus0.s_axis_tvalid = 1'b1;
    bus0.s_axis_tlast  = 1'b0;
    @(posedge clk);  // handshake edge
    #1;
    chk("after_hs_state", state0, 0);
    chk("after_hs_tready", bus0.s_axis_tready, 1);
    chk("after_hs_beat", beat_cnt0, 0);
    chk("after_hs_frame_cnt", frame_cnt0, 2);
    @(posedge clk);  // first beat of next frame accepted
    #1;
    chk("next_first_beat", beat_cnt0, 1);
    bus0.s_axis_tvalid = 1'b0;
    send0(16'h180, 1, 33, 33, 0);
    wait_drain0();

    // Early tlast on beat 5.
    send0(16'h050, 0, 5, 5, 0);
    chk("early_pulse", err_pulse0, 1);
    chk("early_err_cnt", err_cnt0, 1);
    chk("early_state", state0, 0);
    chk("early_no_valid", bus0.out_valid, 0);
    @(posedge clk);
    #1;
    chk("early_pulse_drop", err_pulse0, 0);
    exp_q0.push_back(frame_vec(16'h200));
    send0(16'h200, 0, 33, 33, 0);
    wait_drain0();
    chk("frame_cnt_4", frame_cnt0, 4);

    // Missing tlast, then drain three beats.
    send0(16'h060, 0, 33, -1, 0);
    chk("miss_state_drain", state0, 3);
    chk("miss_pulse", err_pulse0, 1);
    chk("miss_err_cnt", err_cnt0, 2);
    chk("miss_no_valid", bus0.out_valid, 0);
    send0(16'h090, 0, 1, -1, 0);
    chk("drain_stays", state0, 3);
    send0(16'h090, 2, 2, 2, 0);
    chk("drain_exit", state0, 0);
    chk("drain_err_cnt", err_cnt0, 2);
    chk("pulses0", pulses0, 2);

    // Frame with tvalid gaps.
    exp_q0.push_back(frame_vec(16'h280));
    send0(16'h280, 0, 33, 33, 2);
    wait_drain0();
    chk("frame_cnt_5", frame_cnt0, 5);

    // Asynchronous reset mid LOAD_B.
    send0(16'h300, 0, 11, -1, 0);
    chk("pre_rst_state", state0, 1);
    chk("pre_rst_beat", beat_cnt0, 10);
    #2;
    rst_n0 = 1'b0;
    #1;
    chk("arst_state", state0, 0);
    chk("arst_beat", beat_cnt0, 0);
    chk("arst_vec", {bus0.out_b, bus0.out_a}, 0);
    chk("arst_frame_cnt", frame_cnt0, 0);
    chk("arst_err_cnt", err_cnt0, 0);
    chk("arst_flags", {bus0.out_valid, err_pulse0, bus0.s_axis_tready}, 3'b001);
    @(negedge clk);
    rst_n0 = 1'b1;
    @(posedge clk);
    #1;
    exp_q0.push_back(frame_vec(16'h310));
    send0(16'h310, 0, 33, 33, 0);
    wait_drain0();
    chk("post_rst_frame_cnt", frame_cnt0, 1);

    // 64-bit stream: 17-beat frame.
    exp_q1.push_back(frame_vec(16'h400));
    send1(16'h400, 0, 16, 16);
    wait_drain1();
    chk("w64_frame_cnt", frame_cnt1, 1);
    chk("w64_out_a", bus1.out_a, 64'h0403_0402_0401_0400);
    chk("w64_out_b_elem0", bus1.out_b[15:0], 16'h0404);
    chk("w64_out_b_elem63", bus1.out_b[1023:1008], 16'h0443);

    // Error counter saturation with five early-tlast frames.
    for (int n = 1; n <= 5; n++) begin
      int tl;
      tl = (n == 1) ? 0 : (n == 2) ? 1 : (n == 3) ? 2 : (n == 4) ? 0 : 3;
      send1(16'h500, 0, tl, tl);
      chk("w64_early_pulse", err_pulse1, 1);
      chk("w64_err_cnt", err_cnt1, (n > 3) ? 3 : n);
    end
    @(posedge clk);
    #1;
    chk("pulses1", pulses1, 5);
    chk("w64_frame_cnt_end", frame_cnt1, 1);
    chk("queues_empty", exp_q0.size() + exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
